// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter giving N_REQ requesters serialized access to one single-port memory.
// One command in flight; a write retires one cycle after accept, a read responds two cycles after.
module mem_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ-1:0]        i_req_we,
  input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [N_REQ*DATA_W-1:0] i_req_wdata,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_data,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic                    o_mem_en,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [DATA_W-1:0]       o_mem_wdata,
  input  logic [DATA_W-1:0]       i_mem_rdata,
  input  logic                    i_mem_valid,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;

  logic                any_valid;
  logic [IDX_W-1:0]    win_idx;

  // Scan from farthest to nearest so the first valid after the pointer is the last one written.
  always_comb begin : pick
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    any_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand     = (int'(ptr_q) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (i_req_valid[cand_idx]) begin
        any_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(N_REQ - 1);
      gnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = ISSUE;
      ISSUE:   state_d = mem_en_q ? IDLE : RESP;
      RESP:    if (i_rsp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address stays held through ISSUE and RESP so the memory keeps presenting the read word.
  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          ptr_d       = win_idx;
          gnt_d       = win_idx;
          mem_en_d    = i_req_we[win_idx];
          mem_addr_d  = i_req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d = i_req_wdata[int'(win_idx)*DATA_W +: DATA_W];
        end else begin
          mem_en_d = 1'b0;
        end
      end
      ISSUE:   mem_en_d = 1'b0;
      RESP:    if (!i_mem_valid) err_d = 1'b1;
      default: mem_en_d = 1'b0;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    case (state_q)
      IDLE: if (any_valid) o_req_ready[win_idx] = 1'b1;
      RESP: begin
        o_rsp_valid[gnt_q] = 1'b1;
        o_rsp_data         = i_mem_rdata;
      end
      default: o_req_ready = '0;
    endcase
  end

  assign o_mem_en    = mem_en_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = (state_q != IDLE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: behavioural memory, directed scenarios and a randomized run
// checked against a transaction-level round-robin/shadow-memory model.
module tb_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0, req_we = '0, rsp_ready = '1;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [DW-1:0] rsp_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_en, busy, err;
  logic          mem_valid = 1'b0;
  logic          mem_clear = 1'b0;
  logic          force_invalid = 1'b0;
  logic [DW-1:0] mem_arr [16];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .i_rsp_ready(rsp_ready),
    .o_mem_en(mem_en), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid),
    .o_busy(busy), .o_err(err)
  );

  // Synchronous single-port memory: i_EN=1 writes, otherwise reads into a registered output.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
    end else if (mem_en) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_arr[mem_addr];
    mem_valid <= !mem_en && !force_invalid;
  end

  task automatic set_req(input int k, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[k] = v;
    req_we[k]    = we;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic wait_accept(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 1'b0;
    mem_clear = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || req_ready !== '0 ||
        rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      $display("FAIL reset_values: en=%b addr=%h wd=%h rdy=%b rv=%b rd=%h busy=%b err=%b, want all 0",
               mem_en, mem_addr, mem_wdata, req_ready, rsp_valid, rsp_data, busy, err);
    end else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_clear = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_en !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL idle_10_cycles: activity seen with no requests, want quiet");
    else passed++;
  endtask

  task automatic test_write_read();
    bit ok;
    set_req(1, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF);
    wait_accept(1, ok);
    total++;
    if (!ok) $display("FAIL wr_accept: req1 never accepted, want accept");
    else passed++;
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 4'd0, 32'd0);
    set_req(2, 1'b1, 1'b0, 4'd5, 32'd0);
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0000 || busy !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 4'd5 ||
        mem_wdata !== 32'hDEADBEEF)
      $display("FAIL wr_issue: rdy=%b busy=%b en=%b addr=%h wd=%h, want 0000 1 1 5 deadbeef",
               req_ready, busy, mem_en, mem_addr, mem_wdata);
    else passed++;
    wait_accept(2, ok);
    total++;
    if (!ok) $display("FAIL rd_accept: req2 never accepted, want accept");
    else passed++;
    @(posedge clk); #1;
    set_req(2, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0000) $display("FAIL rd_early: rsp_valid=%b one cycle after accept, want 0000", rsp_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 32'hDEADBEEF)
      $display("FAIL rd_resp: rsp_valid=%b data=%h, want 0100 deadbeef", rsp_valid, rsp_data);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0)
      $display("FAIL rd_retire: rsp_valid=%b busy=%b, want 0000 0", rsp_valid, busy);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_rr_order();
    int got;
    int ngrant;
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b1, AW'(8 + k), $urandom);
    ngrant = 0;
    for (int c = 0; c < 40 && ngrant < 8; c++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        got = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) got = k;
        total++;
        if (!$onehot(req_ready) || got != (ngrant % N))
          $display("FAIL rr_grant%0d: ready=%b, want req%0d", ngrant, req_ready, ngrant % N);
        else passed++;
        ngrant++;
      end
    end
    total++;
    if (ngrant != 8) $display("FAIL rr_count: %0d grants seen, want 8", ngrant);
    else passed++;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_rsp_hold();
    bit ok;
    bit bad;
    do_reset();
    rsp_ready = '0;
    set_req(0, 1'b1, 1'b0, 4'd5, 32'd0);
    wait_accept(0, ok);
    total++;
    if (!ok) $display("FAIL hold_accept: req0 never accepted, want accept");
    else passed++;
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 4'd0, 32'd0);
    set_req(3, 1'b1, 1'b1, 4'd3, 32'h33);
    @(negedge clk);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0001 || rsp_data !== 32'hDEADBEEF || req_ready[3] !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL hold_stall: rsp_valid=%b data=%h rdy3=%b, want 0001 deadbeef 0",
                      rsp_valid, rsp_data, req_ready[3]);
    else passed++;
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0001) $display("FAIL hold_last: rsp_valid=%b, want 0001", rsp_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0000 || req_ready !== 4'b1000)
      $display("FAIL hold_release: rsp_valid=%b ready=%b, want 0000 1000", rsp_valid, req_ready);
    else passed++;
    @(posedge clk); #1;
    set_req(3, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_boundary();
    bit ok;
    set_req(0, 1'b1, 1'b1, 4'd15, 32'hFFFFFFFF);
    wait_accept(0, ok);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 4'd0, 32'd0);
    set_req(1, 1'b1, 1'b1, 4'd0, 32'd0);
    wait_accept(1, ok);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 4'd0, 32'd0);
    set_req(2, 1'b1, 1'b0, 4'd15, 32'd0);
    wait_accept(2, ok);
    @(posedge clk); #1;
    set_req(2, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 32'hFFFFFFFF)
      $display("FAIL addr15_read: rsp_valid=%b data=%h, want 0100 ffffffff", rsp_valid, rsp_data);
    else passed++;
    @(posedge clk); #1;
    set_req(3, 1'b1, 1'b0, 4'd0, 32'd0);
    wait_accept(3, ok);
    total++;
    if (!ok) $display("FAIL addr0_accept: req3 never accepted, want accept");
    else passed++;
    @(posedge clk); #1;
    set_req(3, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 32'h0)
      $display("FAIL addr0_read: rsp_valid=%b data=%h, want 1000 00000000", rsp_valid, rsp_data);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_err();
    bit ok;
    total++;
    if (err !== 1'b0) $display("FAIL err_clear: err=%b, want 0", err);
    else passed++;
    force_invalid = 1'b1;
    set_req(1, 1'b1, 1'b0, 4'd5, 32'd0);
    wait_accept(1, ok);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    force_invalid = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1) $display("FAIL err_set: err=%b after invalid read, want 1", err);
    else passed++;
    @(posedge clk); #1;
    set_req(2, 1'b1, 1'b0, 4'd5, 32'd0);
    wait_accept(2, ok);
    @(posedge clk); #1;
    set_req(2, 1'b0, 1'b0, 4'd0, 32'd0);
    repeat (4) @(negedge clk);
    total++;
    if (err !== 1'b1) $display("FAIL err_sticky: err=%b after good read, want 1", err);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    rsp_ready = '0;
    set_req(0, 1'b1, 1'b0, 4'd15, 32'd0);
    wait_accept(0, ok);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'hFFFFFFFF)
      $display("FAIL rstmid_resp: rsp_valid=%b data=%h, want 0001 ffffffff", rsp_valid, rsp_data);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== '0 || busy !== 1'b0 || mem_en !== 1'b0 || err !== 1'b0 || req_ready !== '0)
      $display("FAIL rstmid_drop: rv=%b busy=%b en=%b err=%b rdy=%b, want all 0",
               rsp_valid, busy, mem_en, err, req_ready);
    else passed++;
    rsp_ready = '1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b1, AW'(8 + k), 32'h100 + k);
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (req_ready !== '0) ok = 1'b1;
    end
    total++;
    if (req_ready !== 4'b0001) $display("FAIL rstmid_first: ready=%b, want 0001", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit            pv [N];
    bit            pwe [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic [DW-1:0] shadow [16];
    logic [N-1:0]  exp_ready, exp_rsp;
    logic [DW-1:0] rsp_exp;
    int mptr, next_free, rsp_owner, rsp_start, win, j;
    int errs;
    do_reset();
    for (int i = 0; i < 16; i++) shadow[i] = mem_arr[i];
    for (int k = 0; k < N; k++) begin
      pv[k] = 1'b0; pwe[k] = 1'b0; pa[k] = '0; pd[k] = '0;
    end
    mptr = N - 1; next_free = 0; rsp_owner = -1; rsp_start = 0; rsp_exp = '0;
    errs = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!pv[k] && $urandom_range(0, 2) == 0) begin
          pv[k]  = 1'b1;
          pwe[k] = 1'($urandom_range(0, 1));
          pa[k]  = AW'($urandom_range(0, 3));
          pd[k]  = $urandom;
        end
        set_req(k, pv[k], pwe[k], pa[k], pd[k]);
      end
      rsp_ready = N'($urandom);
      @(negedge clk);
      win = -1;
      if (cyc >= next_free && rsp_owner < 0) begin
        for (int i = 1; i <= N; i++) begin
          j = (mptr + i) % N;
          if (pv[j]) begin
            win = j;
            break;
          end
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_rsp = '0;
      if (rsp_owner >= 0 && cyc >= rsp_start) exp_rsp[rsp_owner] = 1'b1;
      total++;
      if (req_ready !== exp_ready) begin
        if (errs < 10) $display("FAIL rand_ready c%0d: got %b want %b", cyc, req_ready, exp_ready);
        errs++;
      end else passed++;
      total++;
      if (rsp_valid !== exp_rsp || (exp_rsp != '0 && rsp_data !== rsp_exp)) begin
        if (errs < 10) $display("FAIL rand_rsp c%0d: got %b/%h want %b/%h", cyc, rsp_valid, rsp_data,
                                exp_rsp, rsp_exp);
        errs++;
      end else passed++;
      if (exp_rsp != '0 && rsp_ready[rsp_owner]) begin
        rsp_owner = -1;
        next_free = cyc + 1;
      end
      if (win >= 0) begin
        mptr = win;
        pv[win] = 1'b0;
        if (pwe[win]) begin
          shadow[pa[win]] = pd[win];
          next_free = cyc + 2;
        end else begin
          rsp_owner = win;
          rsp_start = cyc + 2;
          rsp_exp   = shadow[pa[win]];
          next_free = 1 << 30;
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) @(negedge clk);
    total++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL rand_end: err=%b busy=%b, want 0 0", err, busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rr_order();
    test_rsp_hold();
    test_boundary();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
